// File: rtl/bj_timer_pkg.sv
// -----------------------------------------------------------------------------
// bj_timer_pkg
// Shared definitions for the two-second timer interface: the delay sequencer
// state encoding and the default width of a period-count request.
// No ports (package).
// -----------------------------------------------------------------------------
package bj_timer_pkg;

    localparam int PERIOD_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/delay_sequencer.sv
// -----------------------------------------------------------------------------
// delay_sequencer
// Initiator side of the two-second timer interface. The game FSM asks for a
// wait of N two-second periods over a valid/ready handshake; this block clears
// and runs the external 2 kHz timer counter once per period and pulses o_Done
// when the last period has elapsed.
//
// Optional build macro: DELAY_SEQ_ABORT_EN adds i_Abort, which cancels an
// in-flight request (CLEAR/RUN) without an o_Done pulse.
//
// Ports
//   clk_2K        in   2 kHz system clock
//   i_Reset       in   synchronous reset, active low
//   i_Req         in   request valid
//   i_Periods     in   periods to wait, sampled on accept (i_Req & o_Ready)
//   o_Ready       out  high in IDLE (and not in reset)
//   o_ActCounter  out  timer activate
//   o_RstCounter  out  timer clear
//   i_TwoSec      in   timer two-second flag
//   o_Busy        out  high in CLEAR/RUN/DONE
//   o_Remaining   out  periods still to elapse
//   o_Done        out  one-cycle completion pulse
//   i_Abort       in   (DELAY_SEQ_ABORT_EN only) cancel current request
// -----------------------------------------------------------------------------
module delay_sequencer
    import bj_timer_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF
) (
    input  logic                clk_2K,
    input  logic                i_Reset,
    input  logic                i_Req,
    input  logic [PERIOD_W-1:0] i_Periods,
    output logic                o_Ready,
    output logic                o_ActCounter,
    output logic                o_RstCounter,
    input  logic                i_TwoSec,
`ifdef DELAY_SEQ_ABORT_EN
    input  logic                i_Abort,
`endif
    output logic                o_Busy,
    output logic [PERIOD_W-1:0] o_Remaining,
    output logic                o_Done
);

    seq_state_t          state, state_nxt;
    logic [PERIOD_W-1:0] remaining, remaining_nxt;

    always_ff @(posedge clk_2K) begin
        if (!i_Reset) begin
            state     <= IDLE;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        case (state)
            IDLE: begin
                if (i_Req) begin
                    // A zero-period request completes without touching the counter.
                    if (i_Periods != '0) begin
                        remaining_nxt = i_Periods;
                        state_nxt     = CLEAR;
                    end else begin
                        state_nxt     = DONE;
                    end
                end
            end
            CLEAR: state_nxt = RUN;
            RUN: begin
                // Re-enter CLEAR between periods so each period counts from 0.
                if (i_TwoSec && remaining != '0) begin
                    remaining_nxt = remaining - PERIOD_W'(1);
                    state_nxt     = (remaining == PERIOD_W'(1)) ? DONE : CLEAR;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
`ifdef DELAY_SEQ_ABORT_EN
        // Abort overrides any same-cycle two-second flag; DONE is left alone.
        if (i_Abort && (state == CLEAR || state == RUN)) begin
            state_nxt     = IDLE;
            remaining_nxt = '0;
        end
`endif
    end

    // Moore decode; reset also forces the counter clear and withdraws ready.
    assign o_Ready      = i_Reset && (state == IDLE);
    assign o_ActCounter = i_Reset && (state == RUN);
    assign o_RstCounter = !i_Reset || (state != RUN);
    assign o_Busy       = (state != IDLE);
    assign o_Done       = (state == DONE);
    assign o_Remaining  = remaining;

endmodule

// File: tb/tb_delay_sequencer.sv
// -----------------------------------------------------------------------------
// tb_delay_sequencer
// Drives delay_sequencer beside a 4-bit timer counter model (terminal 15).
// Expected o_Done cycles are queued on accept; a monitor pops on every o_Done.
// Timing: counter cleared in CLEAR, then RUN sees counts 0..15 (16 cycles) and
// i_TwoSec on count 15, so each period is 17 edges; with accept at edge k the
// o_Done pulse follows edge k+17*N (edge k for N==0).
// -----------------------------------------------------------------------------
module tb_delay_sequencer;

    localparam int PW = 4;

    logic          clk_2K = 1'b0;
    logic          i_Reset = 1'b0;
    logic          i_Req = 1'b0;
    logic [PW-1:0] i_Periods = '0;
    logic          i_TwoSec;
    logic          i_Abort = 1'b0;
    logic          o_Ready, o_ActCounter, o_RstCounter, o_Busy, o_Done;
    logic [PW-1:0] o_Remaining;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_q[$];

    delay_sequencer #(.PERIOD_W(PW)) dut (
        .clk_2K       (clk_2K),
        .i_Reset      (i_Reset),
        .i_Req        (i_Req),
        .i_Periods    (i_Periods),
        .o_Ready      (o_Ready),
        .o_ActCounter (o_ActCounter),
        .o_RstCounter (o_RstCounter),
        .i_TwoSec     (i_TwoSec),
`ifdef DELAY_SEQ_ABORT_EN
        .i_Abort      (i_Abort),
`endif
        .o_Busy       (o_Busy),
        .o_Remaining  (o_Remaining),
        .o_Done       (o_Done)
    );

    always #5 clk_2K = ~clk_2K;
    always @(posedge clk_2K) cyc <= cyc + 1;

    // Timer counter model: clear has priority, increments while active.
    logic [3:0] cnt = 4'd0;
    always @(posedge clk_2K) begin
        if (o_RstCounter)      cnt <= 4'd0;
        else if (o_ActCounter) cnt <= cnt + 4'd1;
    end
    assign i_TwoSec = (cnt == 4'd15) && o_ActCounter && !o_RstCounter;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every o_Done must match the oldest queued expectation.
    always @(negedge clk_2K) begin
        if (o_Done === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_done", cyc, -1);
            else                   chk("done_cycle", cyc, exp_q.pop_front());
        end
    end

    // Present a request; returns at the negedge following the accept edge.
    task automatic issue(input int p, input bit expect_done, input bit hold);
        int n;
        int acc;
        @(negedge clk_2K);
        i_Req = 1'b1;
        i_Periods = PW'(p);
        n = 0;
        while (!o_Ready && n < 50) begin
            @(negedge clk_2K);
            n++;
        end
        if (!o_Ready) chk("ready_timeout", 0, 1);
        acc = cyc + 1;
        if (expect_done) exp_q.push_back(acc + ((p == 0) ? 0 : 17 * p));
        @(negedge clk_2K);
        if (!hold) i_Req = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (!o_Ready && n < bound) begin
            @(negedge clk_2K);
            n++;
        end
        if (!o_Ready) chk("idle_timeout", 0, 1);
        @(negedge clk_2K);
    endtask

    initial begin
        int seq, nts, nclr, act_seen, n;
        logic [PW-1:0] prev;

        // Reset held low for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_2K);
            chk("rst_ready_low", int'(o_Ready), 0);
            chk("rst_rstcnt", int'(o_RstCounter), 1);
        end
        i_Reset = 1'b1;
        @(negedge clk_2K);
        chk("idle_ready", int'(o_Ready), 1);
        chk("idle_busy", int'(o_Busy), 0);
        chk("idle_rem", int'(o_Remaining), 0);
        chk("idle_rstcnt", int'(o_RstCounter), 1);
        chk("idle_act", int'(o_ActCounter), 0);

        // One period.
        issue(1, 1'b1, 1'b0);
        chk("p1_clear_rstcnt", int'(o_RstCounter), 1);
        chk("p1_clear_rem", int'(o_Remaining), 1);
        @(negedge clk_2K);
        chk("p1_run_act", int'(o_ActCounter), 1);
        wait_idle(100);

        // Three periods: track remaining values, flags and inter-period clears.
        issue(3, 1'b1, 1'b0);
        seq = 0; nts = 0; nclr = 0; n = 0;
        prev = o_Remaining;
        seq = int'(prev);
        while (!o_Done && n < 200) begin
            if (o_Busy && o_RstCounter) nclr++;
            if (i_TwoSec) nts++;
            @(negedge clk_2K);
            n++;
            if (o_Remaining != prev) begin
                prev = o_Remaining;
                seq = seq * 16 + int'(prev);
            end
        end
        chk("p3_rem_seq", seq, 'h3210);
        chk("p3_twosec_count", nts, 3);
        chk("p3_clear_cycles", nclr, 3);
        wait_idle(10);

        // Zero periods: immediate DONE, counter never activated.
        issue(0, 1'b1, 1'b0);
        act_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (o_ActCounter) act_seen = 1;
            @(negedge clk_2K);
        end
        chk("p0_act_never", act_seen, 0);
        chk("p0_back_idle", int'(o_Ready), 1);

        // Two periods, i_Req held busy with a different count, reset mid-RUN.
        issue(2, 1'b0, 1'b1);
        i_Periods = PW'(7);
        n = 0;
        while (!o_ActCounter && n < 10) begin
            @(negedge clk_2K);
            n++;
        end
        repeat (5) @(negedge clk_2K);
        chk("held_req_ignored", int'(o_Remaining), 2);
        chk("midrun_busy", int'(o_Busy), 1);
        i_Reset = 1'b0;
        @(negedge clk_2K);
        chk("abort_rst_busy", int'(o_Busy), 0);
        chk("abort_rst_rem", int'(o_Remaining), 0);
        chk("abort_rst_ready", int'(o_Ready), 0);
        chk("abort_rst_rstcnt", int'(o_RstCounter), 1);
        i_Req = 1'b0;
        @(negedge clk_2K);
        i_Reset = 1'b1;
        @(negedge clk_2K);
        chk("post_rst_ready", int'(o_Ready), 1);
        repeat (40) @(negedge clk_2K);
        chk("post_rst_still_idle", int'(o_Busy), 0);

`ifdef DELAY_SEQ_ABORT_EN
        // Five periods, abort coincident with the second two-second flag.
        issue(5, 1'b0, 1'b0);
        nts = 0; n = 0;
        while (nts < 2 && n < 100) begin
            if (i_TwoSec) nts++;
            if (nts < 2) begin
                @(negedge clk_2K);
                n++;
            end
        end
        chk("ab_rem_before", int'(o_Remaining), 4);
        i_Abort = 1'b1;
        @(negedge clk_2K);
        i_Abort = 1'b0;
        chk("ab_busy", int'(o_Busy), 0);
        chk("ab_rem", int'(o_Remaining), 0);
        chk("ab_ready", int'(o_Ready), 1);
        repeat (40) @(negedge clk_2K);
`endif

        // Back-to-back sanity after everything else.
        issue(1, 1'b1, 1'b0);
        wait_idle(100);
        repeat (3) @(negedge clk_2K);
        chk("pending_done", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
